pipe_ctrl: RTL and testbench

- Central pipeline controller for the Y86-64 five-stage core. Sits beside fetch/decode/execute/memory_access/writeback and drives every stage's stall_i/bubble_i.
- Detects load/use hazards, ret processing and jXX mispredicts; contains exceptions.
- Sequences reset flush and run/stop status through an FSM.
- Keeps saturating performance counters.

---
 rtl/pipe_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline controller: load/use, ret and mispredict hazard control,
// exception containment, flush/run/stop sequencing and saturating perf counters.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 5,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       E_dstM_i,
  input  logic             e_cnd_i,
  input  logic [3:0]       M_icode_i,
  input  logic [2:0]       m_stat_i,
  input  logic [2:0]       W_stat_i,
  output logic             F_stall_o,
  output logic             F_bubble_o,
  output logic             D_stall_o,
  output logic             D_bubble_o,
  output logic             E_stall_o,
  output logic             E_bubble_o,
  output logic             M_stall_o,
  output logic             M_bubble_o,
  output logic             W_stall_o,
  output logic             W_bubble_o,
  output logic             halted_o,
  output logic [2:0]       cpu_stat_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] luse_cnt_o,
  output logic [CNT_W-1:0] misp_cnt_o,
  output logic [CNT_W-1:0] ret_cnt_o
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [2:0] S_AOK    = 3'd1;
  localparam logic [2:0] S_HLT    = 3'd2;
  localparam logic [2:0] S_ADR    = 3'd3;
  localparam logic [2:0] S_INS    = 3'd4;

  typedef enum logic [1:0] {ST_FLUSH, ST_RUN, ST_STOP} state_t;

  // A zero-length flush makes RUN the reset state itself.
  localparam state_t RST_STATE = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  state_t          state, next_state;
  logic [FC_W-1:0] flush_cnt;
  logic            luse, retp, misp, exc_m, exc_w, run;

  assign luse  = ((E_icode_i == I_MRMOVQ) || (E_icode_i == I_POPQ)) &&
                 (E_dstM_i != R_NONE) &&
                 ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
  assign retp  = (D_icode_i == I_RET) || (E_icode_i == I_RET) || (M_icode_i == I_RET);
  assign misp  = (E_icode_i == I_JXX) && !e_cnd_i;
  assign exc_m = (m_stat_i == S_HLT) || (m_stat_i == S_ADR) || (m_stat_i == S_INS);
  assign exc_w = (W_stat_i == S_HLT) || (W_stat_i == S_ADR) || (W_stat_i == S_INS);
  assign run   = (state == ST_RUN);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= RST_STATE;
      flush_cnt <= '0;
    end else begin
      state     <= next_state;
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + FC_W'(1) : '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_FLUSH: if (flush_cnt == FC_LAST) next_state = ST_RUN;
      ST_RUN:   if (exc_w) next_state = ST_STOP;
      ST_STOP:  next_state = ST_STOP;
      default:  next_state = RST_STATE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    F_stall_o  = 1'b0;
    F_bubble_o = 1'b0;
    D_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_stall_o  = 1'b0;
    E_bubble_o = 1'b0;
    M_stall_o  = 1'b0;
    M_bubble_o = 1'b0;
    W_stall_o  = 1'b0;
    W_bubble_o = 1'b0;
    case (state)
      ST_FLUSH: begin
        D_bubble_o = 1'b1;
        E_bubble_o = 1'b1;
        M_bubble_o = 1'b1;
        W_bubble_o = 1'b1;
      end
      ST_RUN: begin
        F_stall_o  = luse | retp;
        D_stall_o  = luse;
        D_bubble_o = misp | (!luse & retp);
        E_bubble_o = misp | luse;
        M_bubble_o = exc_m | exc_w;
        W_stall_o  = exc_w;
      end
      ST_STOP: begin
        F_stall_o = 1'b1;
        D_stall_o = 1'b1;
        E_stall_o = 1'b1;
        M_stall_o = 1'b1;
        W_stall_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Final status is captured from writeback only; memory-stage faults may still be squashed.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      halted_o   <= 1'b0;
      cpu_stat_o <= S_AOK;
    end else if (run && exc_w) begin
      halted_o   <= 1'b1;
      cpu_stat_o <= W_stat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cycle_cnt_o <= '0;
      luse_cnt_o  <= '0;
      misp_cnt_o  <= '0;
      ret_cnt_o   <= '0;
    end else if (run) begin
      if (cycle_cnt_o != '1)                 cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
      if (luse && (luse_cnt_o != '1))         luse_cnt_o  <= luse_cnt_o + CNT_W'(1);
      if (misp && (misp_cnt_o != '1))         misp_cnt_o  <= misp_cnt_o + CNT_W'(1);
      if (retp && !luse && (ret_cnt_o != '1)) ret_cnt_o   <= ret_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a default build and a CNT_W=4 / FLUSH_CYCLES=0 build share
// stimulus; both are compared against a cycle-level model of the controller rules.
module tb_pipe_ctrl;

  localparam logic [3:0] NOP = 4'h1, MRM = 4'h5, JXX = 4'h7, RET = 4'h9, POP = 4'hB, NONE = 4'hF;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  localparam logic [9:0] V_FLUSH = 10'b0001010101;
  localparam logic [9:0] V_STOP  = 10'b1010101010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic       e_cnd;
  logic [2:0] m_stat, W_stat;

  logic        f_stall, f_bubble, d_stall, d_bubble, e_stall, e_bubble, m_stall, m_bubble, w_stall, w_bubble;
  logic        halted;
  logic [2:0]  cpu_stat;
  logic [31:0] cycle_cnt, luse_cnt, misp_cnt, ret_cnt;

  logic        f_stall4, f_bubble4, d_stall4, d_bubble4, e_stall4, e_bubble4, m_stall4, m_bubble4, w_stall4, w_bubble4;
  logic        halted4;
  logic [2:0]  cpu_stat4;
  logic [3:0]  cycle_cnt4, luse_cnt4, misp_cnt4, ret_cnt4;

  pipe_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
    .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_cnd_i(e_cnd),
    .M_icode_i(M_icode), .m_stat_i(m_stat), .W_stat_i(W_stat),
    .F_stall_o(f_stall), .F_bubble_o(f_bubble), .D_stall_o(d_stall), .D_bubble_o(d_bubble),
    .E_stall_o(e_stall), .E_bubble_o(e_bubble), .M_stall_o(m_stall), .M_bubble_o(m_bubble),
    .W_stall_o(w_stall), .W_bubble_o(w_bubble),
    .halted_o(halted), .cpu_stat_o(cpu_stat),
    .cycle_cnt_o(cycle_cnt), .luse_cnt_o(luse_cnt), .misp_cnt_o(misp_cnt), .ret_cnt_o(ret_cnt)
  );

  pipe_ctrl #(.FLUSH_CYCLES(0), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n),
    .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
    .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_cnd_i(e_cnd),
    .M_icode_i(M_icode), .m_stat_i(m_stat), .W_stat_i(W_stat),
    .F_stall_o(f_stall4), .F_bubble_o(f_bubble4), .D_stall_o(d_stall4), .D_bubble_o(d_bubble4),
    .E_stall_o(e_stall4), .E_bubble_o(e_bubble4), .M_stall_o(m_stall4), .M_bubble_o(m_bubble4),
    .W_stall_o(w_stall4), .W_bubble_o(w_bubble4),
    .halted_o(halted4), .cpu_stat_o(cpu_stat4),
    .cycle_cnt_o(cycle_cnt4), .luse_cnt_o(luse_cnt4), .misp_cnt_o(misp_cnt4), .ret_cnt_o(ret_cnt4)
  );

  logic [9:0] ctrl, ctrl4;
  assign ctrl  = {f_stall, f_bubble, d_stall, d_bubble, e_stall, e_bubble, m_stall, m_bubble, w_stall, w_bubble};
  assign ctrl4 = {f_stall4, f_bubble4, d_stall4, d_bubble4, e_stall4, e_bubble4, m_stall4, m_bubble4, w_stall4, w_bubble4};

  // Model: remaining flush cycles, stopped flag, latched status, unbounded counts clipped at max.
  typedef struct {
    int         flush_left;
    bit         stop;
    logic [2:0] stat;
    longint     cyc, lu, mp, rt;
  } model_t;

  model_t m8, m4;
  int total, bad;

  function automatic bit luse_f();
    return (E_icode == MRM || E_icode == POP) && E_dstM != NONE && (E_dstM == d_srcA || E_dstM == d_srcB);
  endfunction
  function automatic bit retp_f();
    return D_icode == RET || E_icode == RET || M_icode == RET;
  endfunction
  function automatic bit misp_f();
    return E_icode == JXX && !e_cnd;
  endfunction
  function automatic bit exc_f(logic [2:0] s);
    return s inside {HLT, ADR, INS};
  endfunction

  function automatic model_t reset_model(int flush);
    model_t m;
    m.flush_left = flush;
    m.stop = 1'b0;
    m.stat = AOK;
    m.cyc = 0; m.lu = 0; m.mp = 0; m.rt = 0;
    return m;
  endfunction

  function automatic longint sat(longint v, longint maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  function automatic model_t step(model_t m, longint maxv);
    model_t n = m;
    if (m.flush_left > 0) n.flush_left = m.flush_left - 1;
    else if (!m.stop) begin
      n.cyc = sat(m.cyc, maxv);
      if (luse_f()) n.lu = sat(m.lu, maxv);
      if (misp_f()) n.mp = sat(m.mp, maxv);
      if (retp_f() && !luse_f()) n.rt = sat(m.rt, maxv);
      if (exc_f(W_stat)) begin n.stop = 1'b1; n.stat = W_stat; end
    end
    return n;
  endfunction

  // Per-stage action in RUN: load/use freezes F,D and bubbles E; a taken-wrong jXX
  // squashes D,E; ret holds F and bubbles D unless load/use already holds D.
  function automatic logic [9:0] exp_ctrl(model_t m);
    bit lu = luse_f(), rp = retp_f(), mp = misp_f();
    bit ew = exc_f(W_stat), em = exc_f(m_stat);
    if (m.flush_left > 0) return V_FLUSH;
    if (m.stop) return V_STOP;
    return {lu | rp, 1'b0, lu, mp | (!lu & rp), 1'b0, mp | lu, 1'b0, em | ew, ew, 1'b0};
  endfunction

  task automatic adv();
    if (!rst_n) begin
      m8 = reset_model(5);
      m4 = reset_model(0);
    end else begin
      m8 = step(m8, 64'hFFFF_FFFF);
      m4 = step(m4, 15);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_icode = NOP; M_icode = NOP; E_icode = NOP;
    d_srcA = NONE; d_srcB = NONE; E_dstM = NONE;
    e_cnd = 1'b1; m_stat = AOK; W_stat = AOK;
  endtask

  function automatic logic [3:0] pick_icode();
    case ($urandom_range(0, 9))
      0:       return RET;
      1, 2:    return MRM;
      3:       return POP;
      4, 5:    return JXX;
      6:       return 4'h6;
      default: return NOP;
    endcase
  endfunction

  function automatic logic [3:0] pick_reg();
    logic [3:0] r = 4'($urandom_range(0, 4));
    return (r == 4'd4) ? NONE : r;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    total++; if (ctrl !== V_FLUSH) begin bad++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, V_FLUSH); end
    total++; if (ctrl4 !== 10'b0) begin bad++; $display("FAIL reset_ctrl_noflush got=%b exp=0", ctrl4); end
    total++; if ({cycle_cnt, luse_cnt, misp_cnt, ret_cnt} !== 128'b0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d/%0d/%0d exp=0", cycle_cnt, luse_cnt, misp_cnt, ret_cnt); end
    total++; if ({halted, cpu_stat} !== {1'b0, AOK}) begin
      bad++; $display("FAIL reset_status got=%b/%0d exp=0/1", halted, cpu_stat); end
    adv();
  endtask

  task automatic test_flush();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (ctrl !== V_FLUSH) begin bad++; $display("FAIL flush_ctrl k=%0d got=%b exp=%b", k, ctrl, V_FLUSH); end
      total++; if (cycle_cnt !== 32'd0) begin bad++; $display("FAIL flush_cycle_cnt k=%0d got=%0d exp=0", k, cycle_cnt); end
      adv();
    end
    @(negedge clk);
    total++; if (ctrl !== 10'b0) begin bad++; $display("FAIL first_run_ctrl got=%b exp=0", ctrl); end
    adv();
    total++; if (cycle_cnt !== 32'd1) begin bad++; $display("FAIL first_run_cycle_cnt got=%0d exp=1", cycle_cnt); end
  endtask

  task automatic test_load_use();
    logic [31:0] lu0;
    idle(); E_icode = MRM; E_dstM = 4'd3; d_srcA = 4'd3;
    @(negedge clk);
    total++; if ({f_stall, d_stall, e_bubble, d_bubble} !== 4'b1110) begin
      bad++; $display("FAIL load_use_ctrl got=%b exp=1110", {f_stall, d_stall, e_bubble, d_bubble}); end
    lu0 = luse_cnt;
    adv();
    total++; if (luse_cnt !== lu0 + 32'd1) begin bad++; $display("FAIL load_use_cnt got=%0d exp=%0d", luse_cnt, lu0 + 32'd1); end
    E_dstM = NONE; d_srcA = NONE;
    @(negedge clk);
    total++; if (ctrl !== 10'b0) begin bad++; $display("FAIL load_use_none got=%b exp=0", ctrl); end
    adv();
    idle(); E_icode = POP; E_dstM = 4'd6; d_srcB = 4'd6;
    @(negedge clk);
    total++; if ({f_stall, d_stall, e_bubble, d_bubble} !== 4'b1110) begin
      bad++; $display("FAIL load_use_popq got=%b exp=1110", {f_stall, d_stall, e_bubble, d_bubble}); end
    adv();
  endtask

  task automatic test_mispredict();
    logic [31:0] mp0;
    idle(); E_icode = JXX; e_cnd = 1'b0;
    @(negedge clk);
    total++; if ({d_bubble, e_bubble, f_stall} !== 3'b110) begin
      bad++; $display("FAIL misp_ctrl got=%b exp=110", {d_bubble, e_bubble, f_stall}); end
    mp0 = misp_cnt;
    adv();
    total++; if (misp_cnt !== mp0 + 32'd1) begin bad++; $display("FAIL misp_cnt got=%0d exp=%0d", misp_cnt, mp0 + 32'd1); end
    e_cnd = 1'b1;
    @(negedge clk);
    total++; if (ctrl !== 10'b0) begin bad++; $display("FAIL jxx_taken_ctrl got=%b exp=0", ctrl); end
    adv();
    total++; if (misp_cnt !== mp0 + 32'd1) begin bad++; $display("FAIL jxx_taken_cnt got=%0d exp=%0d", misp_cnt, mp0 + 32'd1); end
  endtask

  task automatic test_ret();
    logic [31:0] r0;
    idle(); D_icode = RET;
    r0 = ret_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if ({f_stall, d_bubble, d_stall} !== 3'b110) begin
        bad++; $display("FAIL ret_ctrl k=%0d got=%b exp=110", k, {f_stall, d_bubble, d_stall}); end
      adv();
    end
    total++; if (ret_cnt !== r0 + 32'd3) begin bad++; $display("FAIL ret_cnt got=%0d exp=%0d", ret_cnt, r0 + 32'd3); end
    E_icode = MRM; E_dstM = 4'd2; d_srcA = 4'd2;
    @(negedge clk);
    total++; if ({f_stall, d_stall, d_bubble, e_bubble} !== 4'b1101) begin
      bad++; $display("FAIL ret_luse_ctrl got=%b exp=1101", {f_stall, d_stall, d_bubble, e_bubble}); end
    adv();
    total++; if (ret_cnt !== r0 + 32'd3) begin bad++; $display("FAIL ret_luse_cnt got=%0d exp=%0d", ret_cnt, r0 + 32'd3); end
    idle();
  endtask

  task automatic test_random(int n);
    for (int k = 0; k < n; k++) begin
      D_icode = pick_icode(); E_icode = pick_icode(); M_icode = pick_icode();
      d_srcA = pick_reg(); d_srcB = pick_reg(); E_dstM = pick_reg();
      e_cnd = 1'($urandom_range(0, 1));
      m_stat = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : AOK;
      W_stat = AOK;
      @(negedge clk);
      total++; if (ctrl !== exp_ctrl(m8)) begin bad++; $display("FAIL rand_ctrl k=%0d got=%b exp=%b", k, ctrl, exp_ctrl(m8)); end
      total++; if (ctrl4 !== exp_ctrl(m4)) begin bad++; $display("FAIL rand_ctrl4 k=%0d got=%b exp=%b", k, ctrl4, exp_ctrl(m4)); end
      total++; if ({f_stall & f_bubble, d_stall & d_bubble, e_stall & e_bubble, m_stall & m_bubble, w_stall & w_bubble} !== 5'b0) begin
        bad++; $display("FAIL rand_stall_and_bubble k=%0d ctrl=%b", k, ctrl); end
      total++; if ({cycle_cnt, luse_cnt, misp_cnt, ret_cnt} !== {32'(m8.cyc), 32'(m8.lu), 32'(m8.mp), 32'(m8.rt)}) begin
        bad++; $display("FAIL rand_counters k=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", k,
          cycle_cnt, luse_cnt, misp_cnt, ret_cnt, m8.cyc, m8.lu, m8.mp, m8.rt); end
      total++; if ({cycle_cnt4, luse_cnt4, misp_cnt4, ret_cnt4} !== {4'(m4.cyc), 4'(m4.lu), 4'(m4.mp), 4'(m4.rt)}) begin
        bad++; $display("FAIL rand_counters4 k=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", k,
          cycle_cnt4, luse_cnt4, misp_cnt4, ret_cnt4, m4.cyc, m4.lu, m4.mp, m4.rt); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL rand_halted k=%0d got=%b exp=0", k, halted); end
      adv();
    end
    idle();
  endtask

  task automatic test_saturation();
    @(negedge clk);
    total++; if (cycle_cnt4 !== 4'd15) begin bad++; $display("FAIL sat_cycle_cnt4 got=%0d exp=15", cycle_cnt4); end
    adv();
    total++; if (cycle_cnt4 !== 4'd15) begin bad++; $display("FAIL sat_hold_cycle_cnt4 got=%0d exp=15", cycle_cnt4); end
  endtask

  task automatic test_exception();
    logic [31:0] c0;
    logic [127:0] snap;
    idle(); m_stat = ADR;
    @(negedge clk);
    total++; if ({m_bubble, w_stall, halted} !== 3'b100) begin
      bad++; $display("FAIL exc_m_ctrl got=%b exp=100", {m_bubble, w_stall, halted}); end
    adv();
    m_stat = AOK; W_stat = ADR;
    @(negedge clk);
    total++; if ({m_bubble, w_stall, halted} !== 3'b110) begin
      bad++; $display("FAIL exc_w_ctrl got=%b exp=110", {m_bubble, w_stall, halted}); end
    c0 = cycle_cnt;
    adv();
    W_stat = AOK;
    @(negedge clk);
    total++; if ({halted, cpu_stat} !== {1'b1, ADR}) begin
      bad++; $display("FAIL stop_status got=%b/%0d exp=1/3", halted, cpu_stat); end
    total++; if (ctrl !== V_STOP) begin bad++; $display("FAIL stop_ctrl got=%b exp=%b", ctrl, V_STOP); end
    total++; if (cycle_cnt !== c0 + 32'd1) begin bad++; $display("FAIL stop_edge_cycle_cnt got=%0d exp=%0d", cycle_cnt, c0 + 32'd1); end
    snap = {cycle_cnt, luse_cnt, misp_cnt, ret_cnt};
    for (int k = 0; k < 4; k++) begin
      D_icode = RET; E_icode = JXX; e_cnd = 1'b0; m_stat = INS;
      adv();
      @(negedge clk);
      total++; if ({cycle_cnt, luse_cnt, misp_cnt, ret_cnt} !== snap) begin
        bad++; $display("FAIL stop_frozen k=%0d got=%0d/%0d/%0d/%0d", k, cycle_cnt, luse_cnt, misp_cnt, ret_cnt); end
      total++; if (ctrl !== V_STOP || ctrl4 !== V_STOP) begin
        bad++; $display("FAIL stop_absorb k=%0d got=%b/%b exp=%b", k, ctrl, ctrl4, V_STOP); end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    #2;
    rst_n = 1'b0;
    m8 = reset_model(5);
    m4 = reset_model(0);
    #1;
    total++; if ({cycle_cnt, luse_cnt, misp_cnt, ret_cnt, 12'(cycle_cnt4), 4'(ret_cnt4)} !== 144'b0) begin
      bad++; $display("FAIL midreset_counters got=%0d/%0d/%0d/%0d/%0d", cycle_cnt, luse_cnt, misp_cnt, ret_cnt, cycle_cnt4); end
    total++; if ({halted, cpu_stat, halted4, cpu_stat4} !== {1'b0, AOK, 1'b0, AOK}) begin
      bad++; $display("FAIL midreset_status got=%b/%0d/%b/%0d exp=0/1/0/1", halted, cpu_stat, halted4, cpu_stat4); end
    total++; if (ctrl !== V_FLUSH) begin bad++; $display("FAIL midreset_ctrl got=%b exp=%b", ctrl, V_FLUSH); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      D_icode = pick_icode(); E_icode = pick_icode(); E_dstM = pick_reg(); d_srcA = pick_reg();
      e_cnd = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++; if (ctrl !== exp_ctrl(m8) || ctrl4 !== exp_ctrl(m4)) begin
        bad++; $display("FAIL reflush_ctrl k=%0d got=%b/%b exp=%b/%b", k, ctrl, ctrl4, exp_ctrl(m8), exp_ctrl(m4)); end
      adv();
    end
    total++; if (cycle_cnt !== 32'(m8.cyc)) begin bad++; $display("FAIL reflush_cycle_cnt got=%0d exp=%0d", cycle_cnt, m8.cyc); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    m8 = reset_model(5);
    m4 = reset_model(0);
    repeat (2) adv();
    test_reset();
    test_flush();
    test_load_use();
    test_mispredict();
    test_ret();
    test_random(300);
    test_saturation();
    test_exception();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
